// File: rtl/pll_lock_mgr_pkg.sv
// Shared types and helpers for the PLL lock manager.
package pll_mgr_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        FILTER    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Bits needed to hold 0..v-1 (at least 1).
    function automatic int clog2(input int unsigned v);
        int r;
        r = 1;
        for (int i = 0; i < 32; i++) begin
            if (((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
        int unsigned top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_mgr_tick_gen.sv
// One divided clock-enable channel, phase-aligned to RUN entry.
module tick_gen #(
    parameter int               DIV_W = 16,
    parameter logic [DIV_W-1:0] DIV   = 16'd1
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    // cnt is the number of cycles until the next tick; parked at 0 outside
    // RUN so the first RUN cycle ticks, then reloaded with DIV-1 after each tick.
    logic [DIV_W-1:0] cnt;

    // Down-counter and registered tick, driven by the upcoming run status.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= DIV - DIV_W'(1);
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - DIV_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL supervision: rPLL reset sequencing, lock filtering, system reset release
// and per-channel clock-enable ticks gated by stable lock.
module pll_lock_mgr
    import pll_mgr_pkg::*;
#(
    parameter int                         NUM_CH       = 2,
    parameter int                         DIV_W        = 16,
    parameter logic [NUM_CH*DIV_W-1:0]    DIV          = {16'd27, 16'd27000},
    parameter int                         LOCK_FILT    = 1024,
    parameter int                         RST_HOLD     = 256,
    parameter int                         LOCK_TIMEOUT = 2700000,
    parameter int                         PLL_RST_LEN  = 32,
    parameter int                         CNT_W        = 8
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic              locked,
    output logic              sys_rst_n,
    output logic [NUM_CH-1:0] tick,
    output logic [CNT_W-1:0]  lost_cnt,
    output logic [CNT_W-1:0]  timeout_cnt
);

    localparam int CTR_W = clog2(max2(max2(LOCK_FILT, RST_HOLD), max2(LOCK_TIMEOUT, PLL_RST_LEN)));
    localparam logic [CTR_W-1:0] RST_END  = CTR_W'(PLL_RST_LEN - 1);
    localparam logic [CTR_W-1:0] TMO_END  = CTR_W'(LOCK_TIMEOUT - 1);
    localparam logic [CTR_W-1:0] FILT_END = CTR_W'(LOCK_FILT - 1);
    localparam logic [CTR_W-1:0] HOLD_END = CTR_W'(RST_HOLD - 1);

    logic             lock_m;
    logic             lock_s;
    state_t           state;
    state_t           state_n;
    logic [CTR_W-1:0] cnt;
    logic             lost_ev;
    logic             tmo_ev;
    logic             run_n;

    // Two-flop synchroniser for the asynchronous LOCK pin.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // State register and shared state counter (cleared on every state change,
    // frozen in RUN where no terminal count applies).
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= PLL_RST;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (state != RUN)
                cnt <= cnt + CTR_W'(1);
        end
    end

    // Next-state logic; lock loss outranks terminal counts in HOLD and RUN.
    always_comb begin
        state_n = state;
        lost_ev = 1'b0;
        tmo_ev  = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == RST_END) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = FILTER;
                end else if (cnt == TMO_END) begin
                    state_n = PLL_RST;
                    tmo_ev  = 1'b1;
                end
            end
            FILTER: begin
                if (!lock_s)              state_n = WAIT_LOCK;
                else if (cnt == FILT_END) state_n = HOLD;
            end
            HOLD: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    lost_ev = 1'b1;
                end else if (cnt == HOLD_END) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    lost_ev = 1'b1;
                end
            end
            default: state_n = PLL_RST;
        endcase
    end

    assign run_n = (state_n == RUN);

    // Registered outputs decoded from the next state so they switch on entry.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset   <= 1'b1;
            locked      <= 1'b0;
            sys_rst_n   <= 1'b0;
            lost_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            pll_reset <= (state_n == PLL_RST);
            locked    <= (state_n == HOLD) || (state_n == RUN);
            sys_rst_n <= run_n;
            if (lost_ev)
                lost_cnt <= CNT_W'(sat_inc(32'(lost_cnt), 32'(CNT_W)));
            if (tmo_ev)
                timeout_cnt <= CNT_W'(sat_inc(32'(timeout_cnt), 32'(CNT_W)));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_tick
        tick_gen #(
            .DIV_W (DIV_W),
            .DIV   (DIV[i*DIV_W +: DIV_W])
        ) u_tick (
            .clkin (clkin),
            .rst_n (rst_n),
            .run   (run_n),
            .tick  (tick[i])
        );
    end

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Scoreboard bench for pll_lock_mgr with a cycle-level behavioural model.
module tb_pll_lock_mgr;

    localparam int NUM_CH       = 2;
    localparam int DIV_W        = 16;
    localparam logic [NUM_CH*DIV_W-1:0] DIV_P = {16'd3, 16'd1};
    localparam int LOCK_FILT    = 4;
    localparam int RST_HOLD     = 3;
    localparam int LOCK_TIMEOUT = 20;
    localparam int PLL_RST_LEN  = 2;
    localparam int CNT_W        = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic              clkin = 1'b0;
    logic              rst_n;
    logic              pll_lock;
    logic              pll_reset;
    logic              locked;
    logic              sys_rst_n;
    logic [NUM_CH-1:0] tick;
    logic [CNT_W-1:0]  lost_cnt;
    logic [CNT_W-1:0]  timeout_cnt;

    pll_lock_mgr #(
        .NUM_CH       (NUM_CH),
        .DIV_W        (DIV_W),
        .DIV          (DIV_P),
        .LOCK_FILT    (LOCK_FILT),
        .RST_HOLD     (RST_HOLD),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .PLL_RST_LEN  (PLL_RST_LEN),
        .CNT_W        (CNT_W)
    ) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .locked      (locked),
        .sys_rst_n   (sys_rst_n),
        .tick        (tick),
        .lost_cnt    (lost_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clkin = ~clkin;

    typedef struct packed {
        logic              pll_reset;
        logic              locked;
        logic              sys_rst_n;
        logic [NUM_CH-1:0] tick;
        logic [CNT_W-1:0]  lost;
        logic [CNT_W-1:0]  tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: phase 0 PLL reset pulse, 1 waiting, 2 filtering,
    // 3 holding system reset, 4 running. age counts edges spent in a phase.
    int div_of[NUM_CH] = '{1, 3};
    int ph, age, run_idx, m_lost, m_tmo;
    bit sync1, sync2;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        ph = 0; age = 0; run_idx = 0; m_lost = 0; m_tmo = 0;
        sync1 = 1'b0; sync2 = 1'b0;
    endtask

    task automatic model_edge(input bit lk);
        bit   ls;
        exp_t e;
        ls    = sync2;
        sync2 = sync1;
        sync1 = lk;
        case (ph)
            0: begin
                age++;
                if (age == PLL_RST_LEN) begin ph = 1; age = 0; end
            end
            1: begin
                if (ls) begin
                    ph = 2; age = 0;
                end else begin
                    age++;
                    if (age == LOCK_TIMEOUT) begin
                        ph = 0; age = 0;
                        if (m_tmo < CNT_MAX) m_tmo++;
                    end
                end
            end
            2: begin
                if (!ls) begin
                    ph = 1; age = 0;
                end else begin
                    age++;
                    if (age == LOCK_FILT) begin ph = 3; age = 0; end
                end
            end
            3: begin
                if (!ls) begin
                    ph = 1; age = 0;
                    if (m_lost < CNT_MAX) m_lost++;
                end else begin
                    age++;
                    if (age == RST_HOLD) begin ph = 4; age = 0; run_idx = 0; end
                end
            end
            default: begin
                if (!ls) begin
                    ph = 1; age = 0;
                    if (m_lost < CNT_MAX) m_lost++;
                end
            end
        endcase
        e.pll_reset = (ph == 0);
        e.locked    = (ph >= 3);
        e.sys_rst_n = (ph == 4);
        e.tick      = '0;
        if (ph == 4) begin
            for (int i = 0; i < NUM_CH; i++)
                e.tick[i] = ((run_idx % div_of[i]) == 0);
            run_idx++;
        end
        e.lost = CNT_W'(m_lost);
        e.tmo  = CNT_W'(m_tmo);
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: entered and left near the falling edge.
    task automatic step(input bit lk);
        pll_lock = lk;
        @(posedge clkin);
        model_edge(lk);
        @(negedge clkin);
    endtask

    task automatic hold_lock(input bit lk, input int n);
        for (int i = 0; i < n; i++) step(lk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_reset"}, int'(pll_reset), 1);
        chk({tag, "_locked"},    int'(locked), 0);
        chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_tick"},      int'(tick), 0);
        chk({tag, "_lost"},      int'(lost_cnt), 0);
        chk({tag, "_tmo"},       int'(timeout_cnt), 0);
    endtask

    // Monitor: every falling edge, compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clkin);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pll_reset",   int'(pll_reset),   int'(e.pll_reset));
                chk("locked",      int'(locked),      int'(e.locked));
                chk("sys_rst_n",   int'(sys_rst_n),   int'(e.sys_rst_n));
                chk("tick",        int'(tick),        int'(e.tick));
                chk("lost_cnt",    int'(lost_cnt),    int'(e.lost));
                chk("timeout_cnt", int'(timeout_cnt), int'(e.tmo));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        model_reset();
        repeat (3) @(negedge clkin);
        chk_reset_values("por");
        rst_n = 1'b1;

        // Watchdog expiry with no lock, then a second PLL reset pulse.
        hold_lock(1'b0, 26);
        // Lock acquisition through to RUN with ticks.
        hold_lock(1'b1, 20);
        // Lock drop in RUN, re-lock.
        hold_lock(1'b0, 4);
        hold_lock(1'b1, 18);
        // Short dropout during FILTER restarts the filter without a loss count.
        hold_lock(1'b0, 4);
        hold_lock(1'b1, 4);
        hold_lock(1'b0, 2);
        hold_lock(1'b1, 18);
        // Repeated losses in RUN drive lost_cnt into saturation.
        for (int k = 0; k < 5; k++) begin
            hold_lock(1'b0, 3);
            hold_lock(1'b1, 16);
        end
        // Randomised lock behaviour, including single-cycle glitches.
        for (int k = 0; k < 60; k++) begin
            bit lk;
            int len;
            lk  = 1'($urandom_range(0, 1));
            len = (k % 7 == 0) ? 1 : int'($urandom_range(1, 14));
            hold_lock(lk, len);
        end
        // Make sure we are in RUN, then assert reset asynchronously mid-cycle.
        hold_lock(1'b1, 16);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async");
        #1 rst_n = 1'b1;
        model_reset();
        hold_lock(1'b0, 5);
        hold_lock(1'b1, 16);

        repeat (2) @(negedge clkin);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
